// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-RAM port between the CPU and a loader, reads take RD_LAT cycles.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise the CPU always wins.
module dmem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_wen,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_wdata,
  output logic        ld_ack,
  output logic [15:0] ld_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wen,
  input  logic [15:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] cnt;
  logic owner, win;
  logic [15:0] sel_addr, sel_wdata;
  logic sel_wen;
`ifdef ARB_RR_EN
  logic last_ld;
  assign win = ld_req && !(cpu_req && last_ld);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_ld <= 1'b1;
    else if (state == IDLE && (cpu_req || ld_req)) last_ld <= win;
`else
  assign win = ld_req && !cpu_req;
`endif
  assign sel_addr  = win ? ld_addr  : cpu_addr;
  assign sel_wdata = win ? ld_wdata : cpu_wdata;
  assign sel_wen   = win ? ld_wen   : cpu_wen;
  assign cpu_stall = cpu_req && !cpu_ack;
  // mem_* double as the latched request while the transaction is in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      case (state)
        IDLE: if (cpu_req || ld_req) begin
          state     <= ACCESS;
          owner     <= win;
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
          mem_wen   <= sel_wen;
        end
        ACCESS: begin
          mem_wen <= 1'b0;
          cnt     <= '0;
          state   <= mem_wen ? DONE : WAIT;
          if (mem_wen) begin
            {ld_ack, cpu_ack} <= owner ? 2'b10 : 2'b01;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        WAIT: if (cnt == 2'(RD_LAT - 1)) begin
          state <= DONE;
          {ld_ack, cpu_ack} <= owner ? 2'b10 : 2'b01;
          if (owner) ld_rdata <= mem_rdata;
          else cpu_rdata <= mem_rdata;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end else cnt <= cnt + 2'd1;
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random two-requester traffic against a transaction-level model with a scoreboard.
module tb_dmem_arbiter;
  localparam int RD_LAT = 3;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic own;
    logic wen;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int ack_cyc;
  } txn_t;

  logic clk = 0, reset_n = 0;
  logic [1:0] req = '0, wen = '0, ack;
  logic [15:0] addr [2], wdata [2];
  logic [15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, mem_wen;
  int checks = 0, errs = 0, cyc = 0, free_at = 0;
  logic last_ld = 1'b1, w;
  txn_t q[$];
  txn_t it;
  logic [15:0] exp_rd [2];
  logic [15:0] ram [65536], exp_mem [65536];
  logic [15:0] pipe [RD_LAT];

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(req[0]), .cpu_wen(wen[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_ack(ack[0]), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(req[1]), .ld_wen(wen[1]), .ld_addr(addr[1]), .ld_wdata(wdata[1]),
    .ld_ack(ack[1]), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    int s = $urandom_range(0, 9);
    return s == 8 ? 16'hFFFF : s == 9 ? 16'h0040 : 16'(s);
  endfunction

  // registered RAM with RD_LAT cycles from address to data
  assign mem_rdata = pipe[RD_LAT-1];
  always @(posedge clk) begin
    pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_wen) ram[mem_addr] <= mem_wdata;
  end

  // transaction model: when free, a sampled request yields one ack 2 (write) or 2+RD_LAT (read) cycles later
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      free_at = 0;
      last_ld = 1'b1;
    end else if (cyc >= free_at && req != 2'b00) begin
      w = (req == 2'b11) ? (RR && !last_ld) : req[1];
      last_ld = w;
      it.own = w;
      it.wen = wen[w];
      it.addr = addr[w];
      it.wdata = wdata[w];
      it.rdata = exp_mem[addr[w]];
      it.ack_cyc = cyc + 1 + (wen[w] ? 0 : RD_LAT);
      if (wen[w]) exp_mem[addr[w]] = wdata[w];
      q.push_back(it);
      free_at = it.ack_cyc + 2;
    end
  end

  // monitor: compares every DUT event against the head of the scoreboard
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      q.delete();
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      chk("cpu_stall", cpu_stall, req[0] && !ack[0]);
      if (mem_wen) begin
        if (q.size() == 0) chk("wen_spurious", 1, 0);
        else begin
          chk("wen_is_write", q[0].wen, 1);
          chk("wen_cycle", cyc, q[0].ack_cyc - 1);
          chk("wen_addr", mem_addr, q[0].addr);
          chk("wen_wdata", mem_wdata, q[0].wdata);
        end
      end
      if (ack != 2'b00) begin
        if (q.size() == 0) chk("ack_spurious", ack, 0);
        else begin
          it = q.pop_front();
          chk("ack_owner", ack, it.own ? 2'b10 : 2'b01);
          chk("ack_cycle", cyc, it.ack_cyc);
          if (!it.wen) exp_rd[it.own] = it.rdata;
        end
      end else if (q.size() == 0) chk("idle_bus", {mem_wen, mem_addr, mem_wdata}, 0);
      chk("cpu_rdata", cpu_rdata, exp_rd[0]);
      chk("ld_rdata", ld_rdata, exp_rd[1]);
    end
  end

  task automatic wait_ack(input int r);
    int n = 0;
    while (!ack[r] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ack[r]) chk("ack_timeout", 0, 1);
    req[r] = 1'b0;
  endtask

  task automatic txn(input int r, input logic wr, input logic [15:0] a, input logic [15:0] d, input bit drop);
    @(negedge clk);
    wen[r] = wr;
    addr[r] = a;
    wdata[r] = d;
    req[r] = 1'b1;
    if (drop) begin
      @(negedge clk);
      req[r] = 1'b0;
    end
    wait_ack(r);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i) ^ 16'hA5C3;
      exp_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_ctl", {mem_wen, ack}, 0);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    txn(0, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    txn(1, 1'b1, 16'hFFFF, 16'h1234, 1'b0);
    txn(1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    txn(0, 1'b0, 16'h0040, 16'h0000, 1'b1);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          txn(0, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom), 1'b0);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          txn(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom), 1'b0);
        end
      end
    join
    fork
      for (int i = 0; i < 2; i++) txn(0, 1'b1, 16'(i), 16'h1000 + 16'(i), 1'b0);
      for (int j = 0; j < 2; j++) txn(1, 1'b1, 16'(j + 4), 16'h2000 + 16'(j), 1'b0);
    join
    @(negedge clk);
    wen[0] = 1'b0;
    addr[0] = 16'h0003;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_bus", {mem_addr, mem_wdata}, 0);
    chk("abort_ctl", {mem_wen, ack}, 0);
    chk("abort_rdata", {cpu_rdata, ld_rdata}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(0);
    repeat (5) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, giving the data-RAM read latency in cycles (legal range 1-3).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the CPU requester ports cpu_req in 1, cpu_wen in 1, cpu_addr in 16, cpu_wdata in 16, cpu_ack out 1, cpu_rdata out 16, and cpu_stall out 1 (CPU must hold PC and registers).
REQ-005 The block SHALL have the loader requester ports ld_req in 1, ld_wen in 1, ld_addr in 16, ld_wdata in 16, ld_ack out 1, and ld_rdata out 16.
REQ-006 The block SHALL have the RAM port A ports mem_addr out 16, mem_wdata out 16, mem_wen out 1, and mem_rdata in 16 (registered RAM output).

Function
REQ-007 The block SHALL use FSM states IDLE, ACCESS, WAIT and DONE.
REQ-008 In IDLE with any req high, the block SHALL select an owner per REQ-013, latch that owner's addr, wdata and wen, and enter ACCESS; with no req it SHALL stay in IDLE.
REQ-009 In ACCESS (one cycle), the block SHALL drive mem_addr and mem_wdata from the latched values and set mem_wen equal to the latched wen; it SHALL go to DONE if the access is a write, else to WAIT with the wait counter cleared.
REQ-010 In WAIT, the block SHALL hold mem_addr, keep mem_wen 0, count RD_LAT cycles, capture mem_rdata into the owner's rdata register on the last count, then go to DONE.
REQ-011 In DONE, the block SHALL pulse the owner's ack high for exactly one cycle and then return to IDLE; the non-owner's ack SHALL stay 0.
REQ-012 Latency SHALL be: req sampled in IDLE at cycle 0; write ack at cycle 2; read ack at cycle 2+RD_LAT, with rdata valid from the ack cycle until that requester's next read completes.
REQ-013 Arbitration SHALL occur only in IDLE; when only one req is high, that requester SHALL win; when both are high, the winner SHALL be as defined in REQ-020/021.
REQ-014 The req, addr, wdata and wen inputs SHALL be ignored outside IDLE; a req dropped mid-transaction SHALL still complete and ack.
REQ-015 A req still high in the cycle after ack SHALL be treated as a new transaction; requesters must deassert req on ack to avoid a repeat.
REQ-016 cpu_stall SHALL equal cpu_req AND NOT cpu_ack, combinationally.
REQ-017 In IDLE, the block SHALL drive mem_addr=0, mem_wdata=0 and mem_wen=0; addresses SHALL pass unmodified, with no wrap or offset (0xFFFF is legal).

Reset
REQ-018 When reset_n is low, the block SHALL immediately force IDLE, the wait counter to 0, all acks to 0, mem_wen to 0, mem_addr and mem_wdata to 0, cpu_rdata and ld_rdata to 0, and the round-robin pointer to "loader last".
REQ-019 A reset asserted mid-transaction SHALL abort it with no ack and no further mem_wen; a request still held after reset release SHALL be re-arbitrated from IDLE.

Configuration
REQ-020 When macro ARB_RR_EN is defined, a round-robin pointer SHALL record the last owner; on simultaneous requests the requester that was not last granted wins, and the pointer updates on entry to ACCESS.
REQ-021 When ARB_RR_EN is undefined, the CPU SHALL always win simultaneous requests and no pointer SHALL be built.

Verification
REQ-022 Scenario: CPU write addr 0x0040 data 0xBEEF, RD_LAT=1 -> mem_wen high for one cycle at cycle 1 with mem_addr 0x0040, and cpu_ack at cycle 2.
REQ-023 Scenario: loader read addr 0xFFFF with RAM holding 0x1234, RD_LAT=3 -> ld_ack at cycle 5 with ld_rdata 0x1234, and mem_wen 0 throughout.
REQ-024 Scenario: both request continuously for 4 transactions -> grant order CPU, LD, CPU, LD when ARB_RR_EN is defined, and CPU on every grant when it is undefined.
REQ-025 Scenario: reset_n pulsed low during WAIT of a CPU read -> no cpu_ack, all outputs 0 within the same cycle, and after release a held cpu_req completes normally.
REQ-026 Scenario: cpu_req held for a read -> cpu_stall high from cycle 0 through cycle 1+RD_LAT and low in the ack cycle.
REQ-027 Scenario: cpu_req dropped during ACCESS -> the transaction still completes and cpu_ack pulses once.
